// File: rtl/dcache_front.sv
`default_nettype none
// ============================================================================
// Module      : dcache_front
// Description : Direct-mapped, write-through, no-write-allocate L1 data cache
//               between the load/store unit and dataMemory. Aligned read hits
//               complete in one cycle; misses, uncacheable (misaligned
//               halfword) accesses and all stores go to dataMemory with the
//               strobes held until mem_ack. One request in flight at a time.
// Ports       : clk, rstn (async, active low), flush
//               LSU side : req_valid/req_ready/req_we/req_size/req_addr/
//                          req_wdata, resp_valid/resp_rdata
//               Mem side : mem_read/mem_write/mem_store_size/mem_cache_miss/
//                          mem_addr/mem_wdata, mem_rdata/mem_ack
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_front #(
    parameter int ADDR_W  = 10,
    parameter int INDEX_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_store_size,
    output logic              mem_cache_miss,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int TAG_W  = ADDR_W - 1 - INDEX_W;
    localparam int NLINES = 1 << INDEX_W;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_mem_rd = 2'd1;
    localparam logic [1:0] c_st_mem_wr = 2'd2;

    logic [1:0]         r_state;
    logic [NLINES-1:0]  r_valid;
    logic [TAG_W-1:0]   r_tag  [NLINES];
    logic [15:0]        r_data [NLINES];

    // Request captured at accept time; used while waiting on memory.
    logic               r_lat_size;
    logic               r_lat_cacheable;
    logic [ADDR_W-1:0]  r_lat_addr;

    logic               r_resp_valid;
    logic [31:0]        r_resp_rdata;
    logic               r_mem_read;
    logic               r_mem_write;
    logic               r_mem_size;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [ADDR_W-1:0]  w_addr_p1;
    logic [INDEX_W-1:0] w_idx_p1;
    logic [TAG_W-1:0]   w_tag_p1;
    logic               w_cacheable;
    logic               w_tag_eq;
    logic               w_hit;
    logic               w_hit_p1;
    logic [15:0]        w_line;
    logic [7:0]         w_hit_byte;
    logic               w_acc;
    logic [INDEX_W-1:0] w_lat_idx;
    logic [TAG_W-1:0]   w_lat_tag;
    logic [7:0]         w_mem_byte;
    logic               w_unused;

    assign w_idx       = req_addr[INDEX_W:1];
    assign w_tag       = req_addr[ADDR_W-1:INDEX_W+1];
    // A misaligned halfword at odd A spans lines idx(A) and idx(A+1).
    assign w_addr_p1   = req_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_idx_p1    = w_addr_p1[INDEX_W:1];
    assign w_tag_p1    = w_addr_p1[ADDR_W-1:INDEX_W+1];
    assign w_cacheable = req_size | ~req_addr[0];
    assign w_tag_eq    = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_hit       = w_tag_eq & w_cacheable;
    assign w_hit_p1    = r_valid[w_idx_p1] & (r_tag[w_idx_p1] == w_tag_p1);
    assign w_line      = r_data[w_idx];
    // Big-endian line: even byte lives in the upper half.
    assign w_hit_byte  = req_addr[0] ? w_line[7:0] : w_line[15:8];
    assign w_lat_idx   = r_lat_addr[INDEX_W:1];
    assign w_lat_tag   = r_lat_addr[ADDR_W-1:INDEX_W+1];
    assign w_mem_byte  = r_lat_addr[0] ? mem_rdata[7:0] : mem_rdata[15:8];
    assign w_unused    = ^{mem_rdata[31:16], w_addr_p1[0]};

    // Gated by rstn so the LSU sees no ready while reset is asserted.
    assign req_ready = rstn & (r_state == c_st_idle) & ~flush;
    assign w_acc     = req_valid & req_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= c_st_idle;
            r_valid         <= '0;
            r_lat_size      <= 1'b0;
            r_lat_cacheable <= 1'b0;
            r_lat_addr      <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= '0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_size      <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            case (r_state)
                c_st_idle: begin
                    if (flush) begin
                        r_valid <= '0;
                    end else if (w_acc) begin
                        r_lat_size      <= req_size;
                        r_lat_cacheable <= w_cacheable;
                        r_lat_addr      <= req_addr;
                        r_mem_size      <= req_size;
                        r_mem_wdata     <= req_wdata;
                        if (!req_we) begin
                            if (w_hit) begin
                                r_resp_valid <= 1'b1;
                                r_resp_rdata <= req_size ? {24'b0, w_hit_byte} : {16'b0, w_line};
                            end else begin
                                r_state    <= c_st_mem_rd;
                                r_mem_read <= 1'b1;
                                r_mem_addr <= w_cacheable ?
                                              {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W-1:1], 1'b0} :
                                              {{(32-ADDR_W){1'b0}}, req_addr};
                            end
                        end else begin
                            // Misaligned halfword store cannot patch lines in
                            // place, so drop any stale copy of either byte.
                            if (!w_cacheable) begin
                                if (w_tag_eq) r_valid[w_idx]    <= 1'b0;
                                if (w_hit_p1) r_valid[w_idx_p1] <= 1'b0;
                            end
                            r_state     <= c_st_mem_wr;
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= {{(32-ADDR_W){1'b0}}, req_addr};
                        end
                    end
                end
                c_st_mem_rd: begin
                    if (mem_ack) begin
                        r_state      <= c_st_idle;
                        r_mem_read   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_lat_size ? {24'b0, w_mem_byte} : {16'b0, mem_rdata[15:0]};
                        if (r_lat_cacheable) r_valid[w_lat_idx] <= 1'b1;
                    end
                end
                c_st_mem_wr: begin
                    if (mem_ack) begin
                        r_state      <= c_st_idle;
                        r_mem_write  <= 1'b0;
                        r_resp_valid <= 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Tag/data arrays need no reset: valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_acc && req_we && w_hit) begin
            if (!req_size)        r_data[w_idx]       <= req_wdata[15:0];
            else if (req_addr[0]) r_data[w_idx][7:0]  <= req_wdata[7:0];
            else                  r_data[w_idx][15:8] <= req_wdata[7:0];
        end
        if ((r_state == c_st_mem_rd) && mem_ack && r_lat_cacheable) begin
            r_data[w_lat_idx] <= mem_rdata[15:0];
            r_tag[w_lat_idx]  <= w_lat_tag;
        end
    end

    assign resp_valid     = r_resp_valid;
    assign resp_rdata     = r_resp_rdata;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_store_size = r_mem_size;
    assign mem_cache_miss = r_mem_read | r_mem_write;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dcache_front.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_front
// Description : Directed self-checking bench for dcache_front. Inputs are
//               driven on the falling edge, outputs sampled on the falling
//               edge; memory responses are supplied by hand with known data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_front;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_size = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write, mem_store_size, mem_cache_miss;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int tests = 0;
    int fails = 0;

    // Observations gathered by mem_serve
    logic        o_rd, o_wr, o_miss, o_size, o_stable, o_rv, o_strobe_after;
    logic [31:0] o_addr, o_wdata, o_rdata;

    dcache_front dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_store_size(mem_store_size),
        .mem_cache_miss(mem_cache_miss), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Present one request; returns at the falling edge after acceptance.
    task automatic issue(input logic we, input logic size, input logic [9:0] addr, input logic [31:0] wd);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wd;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL issue_ready_timeout: got %b exp 1 (addr %h)", req_ready, addr);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Acts as dataMemory: ack after 'delay' cycles with 'rd', recording what
    // the cache presented and what it returned.
    task automatic mem_serve(input int delay, input logic [31:0] rd);
        o_rd = mem_read; o_wr = mem_write; o_miss = mem_cache_miss;
        o_addr = mem_addr; o_size = mem_store_size; o_wdata = mem_wdata;
        o_stable = 1'b1;
        for (int i = 1; i < delay; i++) begin
            @(negedge clk);
            if (mem_read !== o_rd || mem_write !== o_wr || mem_addr !== o_addr ||
                mem_cache_miss !== o_miss || resp_valid !== 1'b0) o_stable = 1'b0;
        end
        mem_ack = 1'b1; mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        o_rv = resp_valid; o_rdata = resp_rdata;
        o_strobe_after = mem_read | mem_write | mem_cache_miss;
    endtask

    task automatic test_reset;
        #3;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b exp 0", req_ready); end
        tests++; if ({resp_valid, mem_read, mem_write, mem_cache_miss, mem_store_size} !== 5'b0 ||
                     resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            fails++; $display("FAIL rst_outputs: got rv%b rd%b wr%b addr %h exp all zero", resp_valid, mem_read, mem_write, mem_addr);
        end
        @(negedge clk); rstn = 1'b1; #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b exp 1", req_ready); end
    endtask

    task automatic test_load_miss_fill;
        issue(1'b0, 1'b0, 10'h010, 32'h0);
        mem_serve(11, 32'h0000ABCD);
        tests++; if (o_rd !== 1'b1 || o_miss !== 1'b1 || o_wr !== 1'b0) begin fails++; $display("FAIL t1_strobes: got rd%b miss%b wr%b exp 1 1 0", o_rd, o_miss, o_wr); end
        tests++; if (o_addr !== 32'h010) begin fails++; $display("FAIL t1_mem_addr: got %h exp 00000010", o_addr); end
        tests++; if (o_stable !== 1'b1) begin fails++; $display("FAIL t1_held: got %b exp 1", o_stable); end
        tests++; if (o_rv !== 1'b1 || o_rdata !== 32'h0000ABCD) begin fails++; $display("FAIL t1_resp: got %b/%h exp 1/0000abcd", o_rv, o_rdata); end
        tests++; if (o_strobe_after !== 1'b0) begin fails++; $display("FAIL t1_strobe_drop: got %b exp 0", o_strobe_after); end
        issue(1'b0, 1'b0, 10'h010, 32'h0);
        tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000ABCD) begin fails++; $display("FAIL t1_rehit: got %b/%h exp 1/0000abcd", resp_valid, resp_rdata); end
        tests++; if (mem_read !== 1'b0 || mem_cache_miss !== 1'b0) begin fails++; $display("FAIL t1_rehit_noread: got %b exp 0", mem_read); end
        @(negedge clk);
        tests++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin fails++; $display("FAIL t1_resp_pulse: got %b/%h exp 0/0", resp_valid, resp_rdata); end
    endtask

    task automatic test_byte_hits;
        issue(1'b0, 1'b1, 10'h011, 32'h0);
        tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h000000CD || mem_read !== 1'b0) begin fails++; $display("FAIL t2_byte_odd: got %b/%h exp 1/000000cd", resp_valid, resp_rdata); end
        issue(1'b0, 1'b1, 10'h010, 32'h0);
        tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h000000AB || mem_read !== 1'b0) begin fails++; $display("FAIL t2_byte_even: got %b/%h exp 1/000000ab", resp_valid, resp_rdata); end
    endtask

    task automatic test_store;
        issue(1'b1, 1'b1, 10'h010, 32'h0000005A);
        mem_serve(3, 32'hDEADBEEF);
        tests++; if (o_wr !== 1'b1 || o_rd !== 1'b0 || o_miss !== 1'b1) begin fails++; $display("FAIL t3_wr_strobes: got wr%b rd%b miss%b exp 1 0 1", o_wr, o_rd, o_miss); end
        tests++; if (o_size !== 1'b1 || o_wdata[7:0] !== 8'h5A || o_addr !== 32'h010) begin fails++; $display("FAIL t3_wr_fields: got sz%b wd %h addr %h exp 1 5a 010", o_size, o_wdata, o_addr); end
        tests++; if (o_rv !== 1'b1 || o_rdata !== 32'h0 || o_strobe_after !== 1'b0) begin fails++; $display("FAIL t3_wr_resp: got %b/%h exp 1/0", o_rv, o_rdata); end
        issue(1'b0, 1'b0, 10'h010, 32'h0);
        tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h00005ACD || mem_read !== 1'b0) begin fails++; $display("FAIL t3_line_update: got %b/%h exp 1/00005acd", resp_valid, resp_rdata); end
        issue(1'b1, 1'b0, 10'h200, 32'h00001234);
        mem_serve(2, 32'h0);
        tests++; if (o_wr !== 1'b1 || o_rd !== 1'b0 || o_addr !== 32'h200 || o_size !== 1'b0 || o_wdata !== 32'h00001234) begin
            fails++; $display("FAIL t3_store_miss: got wr%b rd%b addr %h wd %h exp 1 0 200 00001234", o_wr, o_rd, o_addr, o_wdata);
        end
        issue(1'b0, 1'b0, 10'h200, 32'h0);
        mem_serve(2, 32'h00001234);
        tests++; if (o_rd !== 1'b1) begin fails++; $display("FAIL t3_no_allocate: got %b exp 1", o_rd); end
        tests++; if (o_rdata !== 32'h00001234) begin fails++; $display("FAIL t3_reload_data: got %h exp 00001234", o_rdata); end
    endtask

    task automatic test_conflict;
        issue(1'b0, 1'b0, 10'h030, 32'h0);
        mem_serve(2, 32'h00001111);
        tests++; if (o_rd !== 1'b1 || o_addr !== 32'h030 || o_rdata !== 32'h00001111) begin fails++; $display("FAIL t4_conflict_miss: got rd%b addr %h data %h exp 1 030 00001111", o_rd, o_addr, o_rdata); end
        issue(1'b0, 1'b0, 10'h030, 32'h0);
        tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h00001111) begin fails++; $display("FAIL t4_new_hit: got %b/%h exp 1/00001111", resp_valid, resp_rdata); end
        issue(1'b0, 1'b0, 10'h010, 32'h0);
        mem_serve(2, 32'h00005ACD);
        tests++; if (o_rd !== 1'b1) begin fails++; $display("FAIL t4_evicted: got %b exp 1", o_rd); end
    endtask

    task automatic test_misaligned_flush;
        issue(1'b0, 1'b0, 10'h013, 32'h0);
        mem_serve(2, 32'hFFFF7788);
        tests++; if (o_rd !== 1'b1 || o_addr !== 32'h013) begin fails++; $display("FAIL t5_mis_addr: got rd%b addr %h exp 1 013", o_rd, o_addr); end
        tests++; if (o_rdata !== 32'h00007788) begin fails++; $display("FAIL t5_mis_data: got %h exp 00007788", o_rdata); end
        issue(1'b0, 1'b1, 10'h012, 32'h0);
        mem_serve(2, 32'h0000A1B2);
        tests++; if (o_rd !== 1'b1 || o_addr !== 32'h012) begin fails++; $display("FAIL t5_no_fill: got rd%b addr %h exp 1 012", o_rd, o_addr); end
        tests++; if (o_rdata !== 32'h000000A1) begin fails++; $display("FAIL t5_byte_fill: got %h exp 000000a1", o_rdata); end
        @(negedge clk); flush = 1'b1; #1;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL t5_flush_ready: got %b exp 0", req_ready); end
        @(negedge clk); flush = 1'b0;
        issue(1'b0, 1'b1, 10'h013, 32'h0);
        mem_serve(2, 32'h0000A1B2);
        tests++; if (o_rd !== 1'b1 || o_addr !== 32'h012 || o_rdata !== 32'h000000B2) begin fails++; $display("FAIL t5_flush_byte: got rd%b addr %h data %h exp 1 012 000000b2", o_rd, o_addr, o_rdata); end
        issue(1'b0, 1'b0, 10'h010, 32'h0);
        mem_serve(2, 32'h00005ACD);
        tests++; if (o_rd !== 1'b1) begin fails++; $display("FAIL t5_flush_half: got %b exp 1", o_rd); end
    endtask

    task automatic test_back_to_back;
        // Line 9 holds A1B2 from the refill after flush.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 1'b1; req_addr = 10'h012; #1;
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b exp 1", req_ready); end
        @(negedge clk);
        tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h000000A1) begin fails++; $display("FAIL b2b_first: got %b/%h exp 1/000000a1", resp_valid, resp_rdata); end
        req_addr = 10'h013;
        @(negedge clk);
        req_valid = 1'b0;
        tests++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h000000B2 || mem_read !== 1'b0) begin fails++; $display("FAIL b2b_second: got %b/%h exp 1/000000b2", resp_valid, resp_rdata); end
    endtask

    task automatic test_reset_mid_miss;
        issue(1'b0, 1'b0, 10'h020, 32'h0);
        tests++; if (mem_read !== 1'b1) begin fails++; $display("FAIL t6_miss_start: got %b exp 1", mem_read); end
        @(negedge clk); #2;
        rstn = 1'b0; #1;
        tests++; if (mem_read !== 1'b0 || mem_cache_miss !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            fails++; $display("FAIL t6_async_abort: got rd%b miss%b rdy%b rv%b exp 0 0 0 0", mem_read, mem_cache_miss, req_ready, resp_valid);
        end
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h00009999;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        tests++; if (resp_valid !== 1'b0 || mem_read !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL t6_stray_ack: got rv%b rd%b rdy%b exp 0 0 1", resp_valid, mem_read, req_ready); end
        issue(1'b0, 1'b0, 10'h010, 32'h0);
        mem_serve(2, 32'h00005ACD);
        tests++; if (o_rd !== 1'b1 || o_rdata !== 32'h00005ACD) begin fails++; $display("FAIL t6_cache_empty: got rd%b data %h exp 1 00005acd", o_rd, o_rdata); end
    endtask

    initial begin
        test_reset;
        test_load_miss_fill;
        test_byte_hits;
        test_store;
        test_conflict;
        test_misaligned_flush;
        test_back_to_back;
        test_reset_mid_miss;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
